// File: rtl/led_pkg.sv
// led_pkg: shared FSM state encoding and board constants for the LED breathing block
package led_pkg;
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;
  localparam int CLK_HZ = 25_000_000;
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter with registered duty comparator
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led,
  output logic                period_tick
);
  logic [PWM_BITS-1:0] cnt;
  assign period_tick = cnt == '1;
  // counter runs only while enabled and restarts from 0; led lags the compare by one clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      led <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      led <= cnt < duty;
    end
endmodule

// File: rtl/led_breath_pwm.sv
// led_breath_pwm: breathing LED drive ramping PWM duty up, hold, down, hold while enabled
module led_breath_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 390,
  parameter int HOLD_STEPS   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                cycle_done
);
  localparam int SW = $clog2(STEP_PERIODS + 1);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_PEN = PWM_BITS'(2**PWM_BITS - 2);
  state_t state;
  logic [SW-1:0] step_cnt;
  logic [HW-1:0] hold_cnt;
  logic period_tick, step, run;
  assign run   = en && state != OFF;
  assign step  = period_tick && step_cnt == STEP_LAST;
  assign phase = state;
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .duty        (duty),
    .led         (led),
    .period_tick (period_tick)
  );
  // breath sequencer; dropping en wins over any step in the same clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= OFF;
      duty       <= '0;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else if (!en) begin
      state      <= OFF;
      duty       <= '0;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (state != OFF && period_tick) step_cnt <= step ? '0 : step_cnt + 1'b1;
      case (state)
        OFF: state <= UP;
        UP:
          if (step) begin
            duty <= duty + 1'b1;
            if (duty == DUTY_PEN) begin
              state    <= HOLD_HI;
              hold_cnt <= '0;
            end
          end
        HOLD_HI:
          if (step) begin
            hold_cnt <= hold_cnt == HOLD_LAST ? '0 : hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) state <= DOWN;
          end
        DOWN:
          if (step) begin
            duty <= duty - 1'b1;
            if (duty == PWM_BITS'(1)) begin
              state    <= HOLD_LO;
              hold_cnt <= '0;
            end
          end
        HOLD_LO:
          if (step) begin
            hold_cnt <= hold_cnt == HOLD_LAST ? '0 : hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              state      <= UP;
              cycle_done <= 1'b1;
            end
          end
        default: state <= OFF;
      endcase
    end
endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm: directed self-checking bench for the breathing LED PWM
module tb_led_breath_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic led, cycle_done;
  logic [2:0] duty;
  logic [2:0] phase;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [7:0] pat;
  logic any_hi;
  led_breath_pwm #(.PWM_BITS(3), .STEP_PERIODS(2), .HOLD_STEPS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .led        (led),
    .duty       (duty),
    .phase      (phase),
    .cycle_done (cycle_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (cycle_done) n_done++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    clocks(3);
    check("rst_led", led, 0);
    check("rst_duty", duty, 0);
    check("rst_phase", phase, 0);
    check("rst_done", cycle_done, 0);
    rst_n = 1'b1;
    clocks(1);
    check("up_enter_phase", phase, 1);
    check("up_enter_duty", duty, 0);
    clocks(15);
    check("up_pre_step", duty, 0);
    clocks(1);
    check("up_step1", duty, 1);
    clocks(32);
    check("up_duty3", duty, 3);
    for (int i = 0; i < 8; i++) begin
      clocks(1);
      pat[i] = led;
    end
    check("pwm_shape_d3", pat, 8'b0000_0111);
    clocks(56);
    check("up_duty7", duty, 7);
    check("holdhi_enter", phase, 2);
    for (int i = 0; i < 8; i++) begin
      clocks(1);
      pat[i] = led;
    end
    check("pwm_shape_d7", pat, 8'b0111_1111);
    clocks(7);
    check("holdhi_last", phase, 2);
    clocks(1);
    check("down_enter", phase, 3);
    check("down_duty7", duty, 7);
    clocks(112);
    check("holdlo_enter", phase, 4);
    check("holdlo_duty", duty, 0);
    any_hi = 1'b0;
    for (int i = 0; i < 15; i++) begin
      clocks(1);
      any_hi |= led;
    end
    check("led_duty0", any_hi, 0);
    check("holdlo_last", phase, 4);
    check("pre_done", cycle_done, 0);
    clocks(1);
    check("cycle_done", cycle_done, 1);
    check("cycle_phase", phase, 1);
    check("cycle_duty", duty, 0);
    clocks(1);
    check("done_pulse", cycle_done, 0);
    clocks(176);
    check("down_d4_phase", phase, 3);
    check("down_d4_duty", duty, 4);
    en = 1'b0;
    clocks(1);
    check("drop_phase", phase, 0);
    check("drop_duty", duty, 0);
    check("drop_led", led, 0);
    en = 1'b1;
    clocks(1);
    check("reen_phase", phase, 1);
    check("reen_duty", duty, 0);
    clocks(16);
    check("reen_step1", duty, 1);
    clocks(95);
    check("prio_pre_duty", duty, 6);
    check("prio_pre_phase", phase, 1);
    en = 1'b0;
    clocks(1);
    check("prio_duty", duty, 0);
    check("prio_phase", phase, 0);
    check("prio_done", cycle_done, 0);
    check("done_count", n_done, 1);
    en = 1'b1;
    clocks(49);
    check("async_pre_duty", duty, 3);
    clocks(2);
    check("async_pre_led", led, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", led, 0);
    check("async_duty", duty, 0);
    check("async_phase", phase, 0);
    check("async_done", cycle_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
